// File: rtl/reg_bus_if.sv
// reg_bus_if: APB slave front-end that decodes a word window and hands single
// read/write strobes to a register core, with ack timeout and error counting.
`default_nettype none

module reg_bus_if #(
  parameter int unsigned P_DLY     = 1,
  parameter int unsigned P_BASE    = 12'h120,
  parameter int unsigned P_NREG    = 4,
  parameter int unsigned P_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [11:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  output logic [11:0] reg_addr,
  output logic [31:0] reg_wdata,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  localparam logic [12:0] c_lo   = 13'(P_BASE);
  localparam logic [12:0] c_hi   = 13'(P_BASE + 4 * P_NREG);
  localparam logic [7:0]  c_last = 8'(P_TIMEOUT - 1);

  // Registered assignments are zero-delay in this implementation; the
  // delay parameter is only range-checked alongside the timeout.
  if (P_TIMEOUT < 2 || P_TIMEOUT > 255 || P_DLY > 1000) begin : g_param_check
    $error("reg_bus_if: parameter out of range");
  end

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        write_q;
  logic [31:0] prdata_q;
  logic        pready_q;
  logic        pslverr_q;
  logic        wr_en_q;
  logic        rd_en_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  err_cnt_q;
  logic        w_addr_ok;

  assign w_addr_ok = (paddr[1:0] == 2'b00) &&
                     ({1'b0, paddr} >= c_lo) && ({1'b0, paddr} < c_hi);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      write_q   <= 1'b0;
      prdata_q  <= 32'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= 12'd0;
      wdata_q   <= 32'd0;
      err_cnt_q <= 8'd0;
    end else begin
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (psel && !penable) begin
            write_q <= pwrite;
            if (w_addr_ok) begin
              state_q <= S_WAIT;
              cnt_q   <= 8'd0;
              addr_q  <= {paddr[11:2], 2'b00};
              wdata_q <= pwdata;
              wr_en_q <= pwrite;
              rd_en_q <= !pwrite;
            end else begin
              state_q   <= S_ERR;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
              prdata_q  <= 32'd0;
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
          end
        end
        S_WAIT: begin
          // A dropped select abandons the transfer silently; ack beats timeout.
          if (!psel) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
          end else if (reg_ack) begin
            state_q  <= S_DONE;
            cnt_q    <= 8'd0;
            pready_q <= 1'b1;
            prdata_q <= write_q ? 32'd0 : reg_rdata;
          end else if (cnt_q == c_last) begin
            state_q   <= S_ERR;
            cnt_q     <= 8'd0;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            prdata_q  <= 32'd0;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign reg_wr_en = wr_en_q;
  assign reg_rd_en = rd_en_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_bus_if.sv
// tb_reg_bus_if: directed vector table plus hand-written corner sequences for reg_bus_if.
`default_nettype none

module tb_reg_bus_if;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        reg_wr_en, reg_rd_en;
  logic [11:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;
  int exp_ecnt = 0;

  always #5 clk = ~clk;

  reg_bus_if dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .reg_wr_en (reg_wr_en),
    .reg_rd_en (reg_rd_en),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wd;
    int          ack_at;   // cycle after setup on which ack is driven, 0 = never
    logic [31:0] rd;
    int          lat;      // cycles from setup to pready
    logic        err;
    logic [31:0] prd;
    int          nwr;
    int          nrd;
    logic [11:0] raddr;    // reg_addr seen with the strobe, 0 when none
    logic [31:0] rwd;      // reg_wdata after the transfer
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_xfer(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                         input int ack_at, input logic [31:0] rd,
                         output int lat, output int nwr, output int nrd,
                         output logic err, output logic [31:0] rdat, output logic [11:0] raddr);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; reg_ack = 1'b0;
    lat = -1; nwr = 0; nrd = 0; err = 1'b0; rdat = 32'd0; raddr = 12'd0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      penable = 1'b1;
      if (reg_wr_en) begin nwr++; raddr = reg_addr; end
      if (reg_rd_en) begin nrd++; raddr = reg_addr; end
      if (pready) begin
        lat = k; err = pslverr; rdat = prdata;
        psel = 1'b0; penable = 1'b0; reg_ack = 1'b0;
      end else begin
        reg_ack   = (k == ack_at);
        reg_rdata = (k == ack_at) ? rd : 32'hDEAD_BEEF;
      end
    end
    psel = 1'b0; penable = 1'b0; reg_ack = 1'b0;
  endtask

  int lat, nwr, nrd;
  logic err;
  logic [31:0] rdat;
  logic [11:0] raddr;

  initial begin
    vecs[0]  = '{1'b1, 12'h120, 32'h0A0B0C0D, 1,  32'h0,        2,  1'b0, 32'h0,        1, 0, 12'h120, 32'h0A0B0C0D};
    vecs[1]  = '{1'b0, 12'h12C, 32'h11111111, 4,  32'h01020304, 5,  1'b0, 32'h01020304, 0, 1, 12'h12C, 32'h11111111};
    vecs[2]  = '{1'b0, 12'h130, 32'h22222222, 0,  32'h0,        1,  1'b1, 32'h0,        0, 0, 12'h000, 32'h11111111};
    vecs[3]  = '{1'b1, 12'h122, 32'hFFFF0000, 0,  32'h0,        1,  1'b1, 32'h0,        0, 0, 12'h000, 32'h11111111};
    vecs[4]  = '{1'b0, 12'h124, 32'h0,        0,  32'h0,        17, 1'b1, 32'h0,        0, 1, 12'h124, 32'h0};
    vecs[5]  = '{1'b0, 12'h124, 32'h0,        16, 32'h55AA33CC, 17, 1'b0, 32'h55AA33CC, 0, 1, 12'h124, 32'h0};
    vecs[6]  = '{1'b0, 12'h11C, 32'h33333333, 0,  32'h0,        1,  1'b1, 32'h0,        0, 0, 12'h000, 32'h0};
    vecs[7]  = '{1'b1, 12'h12C, 32'h87654321, 2,  32'h0,        3,  1'b0, 32'h0,        1, 0, 12'h12C, 32'h87654321};
    vecs[8]  = '{1'b0, 12'h120, 32'h0,        1,  32'hCAFEF00D, 2,  1'b0, 32'hCAFEF00D, 0, 1, 12'h120, 32'h0};
    vecs[9]  = '{1'b1, 12'h121, 32'h44444444, 0,  32'h0,        1,  1'b1, 32'h0,        0, 0, 12'h000, 32'h0};
    vecs[10] = '{1'b1, 12'h128, 32'h5A5A5A5A, 1,  32'h0,        2,  1'b0, 32'h0,        1, 0, 12'h128, 32'h5A5A5A5A};

    reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 12'h0; pwdata = 32'h0; reg_rdata = 32'h0; reg_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst prdata",  prdata, 32'h0);
    chk("rst pready",  {31'd0, pready}, 32'h0);
    chk("rst pslverr", {31'd0, pslverr}, 32'h0);
    chk("rst wr_en",   {31'd0, reg_wr_en}, 32'h0);
    chk("rst rd_en",   {31'd0, reg_rd_en}, 32'h0);
    chk("rst addr",    {20'd0, reg_addr}, 32'h0);
    chk("rst wdata",   reg_wdata, 32'h0);
    chk("rst err_cnt", {24'd0, err_cnt}, 32'h0);
    reset_n = 1'b1;

    // reg_ack is meaningless while idle
    reg_ack = 1'b1; reg_rdata = 32'h12345678;
    repeat (3) begin
      @(negedge clk);
      chk("idle ack pready", {31'd0, pready}, 32'h0);
    end
    reg_ack = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].ack_at, vecs[i].rd,
              lat, nwr, nrd, err, rdat, raddr);
      if (vecs[i].err) exp_ecnt++;
      chk($sformatf("v%0d lat", i),     32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d pslverr", i), {31'd0, err}, {31'd0, vecs[i].err});
      chk($sformatf("v%0d prdata", i),  rdat, vecs[i].prd);
      chk($sformatf("v%0d n_wr", i),    32'(nwr), 32'(vecs[i].nwr));
      chk($sformatf("v%0d n_rd", i),    32'(nrd), 32'(vecs[i].nrd));
      chk($sformatf("v%0d reg_addr", i), {20'd0, raddr}, {20'd0, vecs[i].raddr});
      chk($sformatf("v%0d reg_wdata", i), reg_wdata, vecs[i].rwd);
      chk($sformatf("v%0d err_cnt", i), {24'd0, err_cnt}, 32'(exp_ecnt));
    end

    // psel dropped in WAIT: silent abort, later ack ignored
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h128;
    @(negedge clk); penable = 1'b1;
    chk("abort strobe", {31'd0, reg_rd_en}, 32'h1);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    reg_ack = 1'b1; reg_rdata = 32'h77;
    repeat (3) begin
      chk("abort pready", {31'd0, pready}, 32'h0);
      @(negedge clk);
    end
    reg_ack = 1'b0;
    chk("abort err_cnt", {24'd0, err_cnt}, 32'(exp_ecnt));

    // setup phase while in WAIT is ignored
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h124;
    @(negedge clk); paddr = 12'h130; pwrite = 1'b1;
    @(negedge clk);
    chk("busy setup pready", {31'd0, pready}, 32'h0);
    chk("busy setup wr_en", {31'd0, reg_wr_en}, 32'h0);
    reg_ack = 1'b1; reg_rdata = 32'h13579BDF;
    @(negedge clk);
    reg_ack = 1'b0; psel = 1'b0;
    chk("busy pready",  {31'd0, pready}, 32'h1);
    chk("busy pslverr", {31'd0, pslverr}, 32'h0);
    chk("busy prdata",  prdata, 32'h13579BDF);
    chk("busy reg_addr", {20'd0, reg_addr}, 32'h124);
    @(negedge clk);
    chk("pready one cycle", {31'd0, pready}, 32'h0);

    // reset pulse in WAIT, then a late ack
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h128;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); reset_n = 1'b0;
    #1;
    chk("mid rst prdata",  prdata, 32'h0);
    chk("mid rst pready",  {31'd0, pready}, 32'h0);
    chk("mid rst strobes", {30'd0, reg_wr_en, reg_rd_en}, 32'h0);
    chk("mid rst addr",    {20'd0, reg_addr}, 32'h0);
    chk("mid rst err_cnt", {24'd0, err_cnt}, 32'h0);
    exp_ecnt = 0;
    @(negedge clk); reset_n = 1'b1; reg_ack = 1'b1; reg_rdata = 32'hFACEFACE;
    repeat (3) begin
      @(negedge clk);
      chk("late ack pready", {31'd0, pready}, 32'h0);
      chk("late ack strobe", {30'd0, reg_wr_en, reg_rd_en}, 32'h0);
    end
    reg_ack = 1'b0; psel = 1'b0; penable = 1'b0;
    do_xfer(1'b0, 12'h128, 32'h0, 2, 32'h600DF00D, lat, nwr, nrd, err, rdat, raddr);
    chk("post rst lat", 32'(lat), 32'd3);
    chk("post rst pslverr", {31'd0, err}, 32'h0);
    chk("post rst prdata", rdat, 32'h600DF00D);

    // saturation of the error counter
    for (int i = 0; i < 300; i++)
      do_xfer(1'b1, 12'h000, 32'h0, 0, 32'h0, lat, nwr, nrd, err, rdat, raddr);
    chk("sat err_cnt", {24'd0, err_cnt}, 32'hFF);
    do_xfer(1'b1, 12'h120, 32'h1, 1, 32'h0, lat, nwr, nrd, err, rdat, raddr);
    chk("sat legal pslverr", {31'd0, err}, 32'h0);
    chk("sat legal err_cnt", {24'd0, err_cnt}, 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/reg_bus_if.md
REG_BUS_IF -- requirements
Module: reg_bus_if

Interface
REQ-001 Parameter P_DLY, default 1: simulation delay applied to every registered assignment.
REQ-002 Parameter P_BASE, default 12'h120: byte address of the first register in the decoded window.
REQ-003 Parameter P_NREG, default 4: number of 32-bit words in the window (window = P_BASE .. P_BASE+4*P_NREG-1).
REQ-004 Parameter P_TIMEOUT, default 16: maximum number of WAIT cycles allowed for reg_ack, legal range 2..255.
REQ-005 clk  in  1  single clock; all logic is on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 psel  in  1  APB select.
REQ-008 penable  in  1  APB enable, marks the access phase.
REQ-009 pwrite  in  1  1 = write, 0 = read.
REQ-010 paddr  in  12  APB byte address.
REQ-011 pwdata  in  32  APB write data.
REQ-012 prdata  out  32  APB read data, registered.
REQ-013 pready  out  1  APB ready, registered, one-cycle pulse.
REQ-014 pslverr  out  1  APB error, valid only while pready=1.
REQ-015 reg_wr_en  out  1  one-cycle write strobe to the register core.
REQ-016 reg_rd_en  out  1  one-cycle read strobe to the register core.
REQ-017 reg_addr  out  12  latched word-aligned address.
REQ-018 reg_wdata  out  32  latched write data.
REQ-019 reg_rdata  in  32  read data from the register core, valid when reg_ack=1.
REQ-020 reg_ack  in  1  register core completion.
REQ-021 err_cnt  out  8  saturating count of error responses.

Function
REQ-022 The FSM SHALL have four states: IDLE, WAIT, DONE and ERR, with IDLE as the reset state.
REQ-023 IDLE: on psel=1 and penable=0 (setup phase), the block SHALL latch paddr, pwdata and pwrite.
REQ-024 IDLE decode: an address is legal when paddr[1:0]=0 and it lies inside the window. For a legal address the FSM SHALL go to WAIT and pulse reg_wr_en or reg_rd_en for exactly one cycle, in the first WAIT cycle. For an illegal address the FSM SHALL go to ERR and SHALL NOT pulse either strobe.
REQ-025 WAIT: a cycle counter SHALL start at 0 in the first WAIT cycle and increment once per cycle.
REQ-026 WAIT: when reg_ack=1, the FSM SHALL go to DONE. On a read it SHALL also capture reg_rdata into prdata.
REQ-027 WAIT: when the counter equals P_TIMEOUT-1 and reg_ack=0, the FSM SHALL go to ERR.
REQ-028 WAIT: if reg_ack=1 on the timeout cycle, ack SHALL win and the FSM SHALL go to DONE.
REQ-029 DONE: pready=1 and pslverr=0 for one cycle, then IDLE. On a write, prdata SHALL be 0.
REQ-030 ERR: pready=1, pslverr=1 and prdata=0 for one cycle, then IDLE. err_cnt SHALL increment and saturate at 8'hFF.
REQ-031 Timing: setup at cycle T gives strobe at T+1. With ack at T+1, pready SHALL assert at T+2. An illegal address gives pready at T+1.
REQ-032 reg_ack SHALL be ignored in IDLE, DONE and ERR.
REQ-033 WAIT: if psel drops to 0, the FSM SHALL return to IDLE the next cycle with no pready, and a later ack SHALL be ignored.
REQ-034 reg_addr and reg_wdata SHALL hold their values until the next legal setup phase.
REQ-035 A setup phase that arrives while the FSM is not in IDLE SHALL be ignored.

Reset
REQ-036 While reset_n=0, the block SHALL force: state=IDLE, counter=0, prdata=0, pready=0, pslverr=0, reg_wr_en=0, reg_rd_en=0, reg_addr=0, reg_wdata=0, err_cnt=0.
REQ-037 Reset asserted mid-transfer SHALL abort the transfer immediately, with no pready and no strobe after release.

Verification
REQ-038 Write 0x120 data 0x0A0B0C0D, ack in the strobe cycle -> reg_wr_en one cycle at T+1 with reg_addr=0x120, pready=1 and pslverr=0 at T+2.
REQ-039 Read 0x12C, ack 3 cycles after the strobe with reg_rdata=0x01020304 -> prdata=0x01020304 with pready at T+5 and pslverr=0.
REQ-040 Read 0x130 and write 0x122 -> no strobe, pready=1 and pslverr=1 at T+1, err_cnt 0 -> 2.
REQ-041 Read 0x124 with no ack -> pslverr=1 at T+1+P_TIMEOUT (T+17 at default). A second run with ack exactly on counter=15 -> DONE, pslverr=0.
REQ-042 reset_n pulsed low during WAIT, then a late ack -> all outputs 0, no pready, and the next transfer completes normally.
REQ-043 Force 300 illegal accesses -> err_cnt=8'hFF, then one legal access -> err_cnt stays 8'hFF.
